// File: rtl/vga_piso_shifter_pkg.sv
// Shared types and helpers for the VGA parallel-in/serial-out pixel shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vga_piso_pkg;

  // Width of the underrun statistics counter when it is built in.
  localparam int UNDERRUN_CNT_W = 16;

  // Shifter state encoding: EMPTY = no word loaded, SHIFT = word being serialised.
  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } shift_state_e;

  // Width of a counter that indexes the bits of a data_w-bit word.
  function automatic int bit_cnt_w(input int data_w);
    return (data_w <= 1) ? 1 : $clog2(data_w);
  endfunction

endpackage

// File: rtl/vga_piso_shifter_if.sv
// Load-side valid/ready bundle feeding words into the pixel shifter.
// Latency: n/a (wires only).
// Backpressure: ready is owned by the slave (shifter) and gates the transfer.
interface vga_piso_shifter_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 1
);

  logic [NUM_CH*DATA_W-1:0] load_data;
  logic                     load_valid;
  logic                     load_ready;

  // Word source: presents data/valid, observes ready.
  modport master (
    output load_data,
    output load_valid,
    input  load_ready
  );

  // Shifter side: consumes data/valid, drives ready.
  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready
  );

endinterface

// File: rtl/vga_piso_shifter_lane_mux.sv
// Per-lane bit picker: selects the bit of one word indexed by bit_cnt in the chosen order.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module vga_piso_lane_mux
  import vga_piso_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BCW    = bit_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] word,
  input  logic [BCW-1:0]    bit_cnt,
  input  logic              msb_q,
  output logic              pix
);

  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  logic [BCW-1:0] idx;

  // Map the sequence position to a physical bit: count down from the top in MSB-first mode.
  always_comb begin
    idx = bit_cnt;
    if (msb_q) begin
      idx = LAST_BIT - bit_cnt;
    end
  end

  assign pix = word[idx];

endmodule

// File: rtl/vga_piso_shifter.sv
// Multi-lane VGA pixel shifter: one-word holding buffer feeding a replicating PISO shift stage.
// Latency: first bit of a word appears one clock after the transfer cycle; words chain gap-free.
// Backpressure: load_ready = !hold_valid, a registered decode independent of load_valid.
// Optional: define VGA_PISO_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_count output.
module vga_piso_shifter
  import vga_piso_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 1,
  parameter int SCALE_W = 2
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic                  display_area,
  vga_piso_shifter_if.slave     load,
  input  logic                  msb_first,
  input  logic [SCALE_W-1:0]    scale,
  output logic [NUM_CH-1:0]     serial_output,
  output logic                  underrun
`ifdef VGA_PISO_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

  localparam int BCW = bit_cnt_w(DATA_W);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  // Holding buffer: one word waiting behind the shift stage.
  logic [NUM_CH*DATA_W-1:0] hold_data;
  logic                     hold_valid;

  // Shift stage: the word on screen plus its own sampled order/scale.
  shift_state_e             state;
  logic [NUM_CH*DATA_W-1:0] shift_data;
  logic                     msb_q;
  logic [SCALE_W-1:0]       scale_q;
  logic [BCW-1:0]           bit_cnt;
  logic [SCALE_W-1:0]       rep_cnt;

  // Decoded control.
  logic                     accept;
  logic                     word_done;
  logic                     xfer;
  logic                     starve;
  logic [BCW-1:0]           bit_nxt;
  logic [SCALE_W-1:0]       rep_nxt;

  // Lane mux operands: the hold word at a transfer, otherwise the shifting word.
  logic [NUM_CH*DATA_W-1:0] mux_word;
  logic [BCW-1:0]           mux_cnt;
  logic                     mux_msb;
  logic [NUM_CH-1:0]        lane_bit;

  assign load.load_ready = !hold_valid;
  assign accept          = load.load_valid && !hold_valid;

  // Word-done / transfer / starvation decode and next-position counters.
  always_comb begin
    word_done = (state == SHIFT) && (bit_cnt == LAST_BIT) && (rep_cnt == scale_q);
    xfer      = display_area && hold_valid && ((state == EMPTY) || word_done);
    starve    = display_area && !hold_valid && ((state == EMPTY) || word_done);
    bit_nxt   = bit_cnt;
    rep_nxt   = rep_cnt + SCALE_W'(1);
    if (rep_cnt == scale_q) begin
      rep_nxt = '0;
      bit_nxt = bit_cnt + BCW'(1);
    end
  end

  // Counters track the bit currently on screen, so the mux looks at the next position.
  always_comb begin
    mux_word = shift_data;
    mux_cnt  = bit_nxt;
    mux_msb  = msb_q;
    if (xfer) begin
      mux_word = hold_data;
      mux_cnt  = '0;
      mux_msb  = msb_first;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    vga_piso_lane_mux #(
      .DATA_W (DATA_W),
      .BCW    (BCW)
    ) u_lane_mux (
      .word    (mux_word[c*DATA_W +: DATA_W]),
      .bit_cnt (mux_cnt),
      .msb_q   (mux_msb),
      .pix     (lane_bit[c])
    );
  end

  // Holding buffer: fill on accept, drain on transfer; the two are mutually exclusive.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_data  <= load.load_data;
      hold_valid <= 1'b1;
    end else if (xfer) begin
      hold_valid <= 1'b0;
    end
  end

  // Shifter FSM with registered pixel and underrun outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state         <= EMPTY;
      shift_data    <= '0;
      msb_q         <= 1'b0;
      scale_q       <= '0;
      bit_cnt       <= '0;
      rep_cnt       <= '0;
      serial_output <= '0;
      underrun      <= 1'b0;
    end else if (!display_area) begin
      // Blanking: drop the on-screen word but leave the holding buffer alone.
      state         <= EMPTY;
      bit_cnt       <= '0;
      rep_cnt       <= '0;
      serial_output <= '0;
      underrun      <= 1'b0;
    end else if (xfer) begin
      state         <= SHIFT;
      shift_data    <= hold_data;
      msb_q         <= msb_first;
      scale_q       <= scale;
      bit_cnt       <= '0;
      rep_cnt       <= '0;
      serial_output <= lane_bit;
      underrun      <= 1'b0;
    end else if (starve) begin
      // Nothing to show for the coming pixel: blank it and flag the starvation.
      state         <= EMPTY;
      bit_cnt       <= '0;
      rep_cnt       <= '0;
      serial_output <= '0;
      underrun      <= 1'b1;
    end else begin
      bit_cnt       <= bit_nxt;
      rep_cnt       <= rep_nxt;
      serial_output <= lane_bit;
      underrun      <= 1'b0;
    end
  end

`ifdef VGA_PISO_UNDERRUN_CNT_EN
  // Saturating count of starved display cycles, stepped alongside the underrun pulse.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (starve && (underrun_count != {UNDERRUN_CNT_W{1'b1}})) begin
      underrun_count <= underrun_count + UNDERRUN_CNT_W'(1);
    end
  end
`else
  // Only the underrun pulse is exported in this build.
`endif

endmodule

// File: tb/tb_vga_piso_shifter.sv
module tb_vga_piso_shifter;
  localparam int DATA_W  = 8;
  localparam int NUM_CH  = 3;
  localparam int SCALE_W = 2;

  logic                 vga_clk;
  logic                 reset;
  logic                 display_area;
  logic                 msb_first;
  logic [SCALE_W-1:0]   scale;
  logic [NUM_CH-1:0]    serial_output;
  logic                 underrun;
`ifdef VGA_PISO_UNDERRUN_CNT_EN
  logic [15:0]          underrun_count;
`endif

  int ntests = 0;
  int nfail  = 0;

  vga_piso_shifter_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) ld ();

  vga_piso_shifter #(
    .DATA_W  (DATA_W),
    .NUM_CH  (NUM_CH),
    .SCALE_W (SCALE_W)
  ) dut (
    .vga_clk        (vga_clk),
    .reset          (reset),
    .display_area   (display_area),
    .load           (ld),
    .msb_first      (msb_first),
    .scale          (scale),
    .serial_output  (serial_output),
    .underrun       (underrun)
`ifdef VGA_PISO_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  // Present one word for a single accepting edge while load_ready is high.
  task automatic load_word(input logic [NUM_CH*DATA_W-1:0] w);
    ld.load_data  = w;
    ld.load_valid = 1'b1;
    step();
    ld.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    if (serial_output !== 3'b000) begin
      nfail++; $display("FAIL reset_serial: got %b want 000", serial_output);
    end
    ntests++;
    if (underrun !== 1'b0) begin
      nfail++; $display("FAIL reset_underrun: got %b want 0", underrun);
    end
    ntests++;
    if (ld.load_ready !== 1'b1) begin
      nfail++; $display("FAIL reset_ready: got %b want 1", ld.load_ready);
    end
    ntests++;
    reset = 1'b0;
  endtask

  task automatic test_underrun();
    display_area = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (underrun !== 1'b1 || serial_output !== 3'b000) begin
        nfail++; $display("FAIL underrun_pulse[%0d]: got ur=%b out=%b want ur=1 out=000", i, underrun, serial_output);
      end
      ntests++;
`ifdef VGA_PISO_UNDERRUN_CNT_EN
      if (underrun_count !== 16'(i + 1)) begin
        nfail++; $display("FAIL underrun_count[%0d]: got %0d want %0d", i, underrun_count, i + 1);
      end
      ntests++;
`endif
    end
    display_area = 1'b0;
    step();
    if (underrun !== 1'b0) begin
      nfail++; $display("FAIL underrun_blank: got %b want 0", underrun);
    end
    ntests++;
  endtask

  task automatic test_msb_first();
    logic [7:0] w;
    logic [2:0] exp;
    w = 8'hA5;
    msb_first = 1'b1;
    scale = 2'd0;
    load_word({3{w}});
    if (ld.load_ready !== 1'b0) begin
      nfail++; $display("FAIL msb_held_ready: got %b want 0", ld.load_ready);
    end
    ntests++;
    display_area = 1'b1;
    step();
    if (ld.load_ready !== 1'b1) begin
      nfail++; $display("FAIL msb_ready_after_xfer: got %b want 1", ld.load_ready);
    end
    ntests++;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      exp = {3{w[7-i]}};
      if (serial_output !== exp) begin
        nfail++; $display("FAIL msb_bit[%0d]: got %b want %b", i, serial_output, exp);
      end
      ntests++;
    end
    step();
    if (serial_output !== 3'b000) begin
      nfail++; $display("FAIL msb_after_word: got %b want 000", serial_output);
    end
    ntests++;
    display_area = 1'b0;
    step();
  endtask

  task automatic test_lsb_scale();
    logic [15:0] seq;
    logic [2:0]  exp;
    seq = 16'b1100110000110011;
    msb_first = 1'b0;
    scale = 2'd1;
    load_word({3{8'hA5}});
    display_area = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (i == 1) begin
        scale = 2'd3;
        msb_first = 1'b1;
      end
      exp = {3{seq[15-i]}};
      if (serial_output !== exp) begin
        nfail++; $display("FAIL lsb_scale[%0d]: got %b want %b", i, serial_output, exp);
      end
      ntests++;
    end
    display_area = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp;
    msb_first = 1'b1;
    scale = 2'd0;
    load_word({3{8'h00}});
    display_area = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (i == 2) ld.load_valid = 1'b0;
      exp = (i < 8) ? 3'b000 : 3'b111;
      if (serial_output !== exp || underrun !== 1'b0) begin
        nfail++; $display("FAIL b2b[%0d]: got out=%b ur=%b want out=%b ur=0", i, serial_output, underrun, exp);
      end
      ntests++;
      if (i == 8 && ld.load_ready !== 1'b1) begin
        nfail++; $display("FAIL b2b_ready: got %b want 1", ld.load_ready);
      end
      if (i == 8) ntests++;
      if (i == 1) begin
        ld.load_data  = {3{8'hFF}};
        ld.load_valid = 1'b1;
      end
    end
    display_area = 1'b0;
    step();
  endtask

  task automatic test_multi_lane();
    logic [7:0] l2, l1, l0;
    logic [2:0] exp;
    l2 = 8'hF0; l1 = 8'h0F; l0 = 8'hAA;
    msb_first = 1'b1;
    scale = 2'd0;
    load_word({l2, l1, l0});
    display_area = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      exp = {l2[7-i], l1[7-i], l0[7-i]};
      if (serial_output !== exp) begin
        nfail++; $display("FAIL lanes[%0d]: got %b want %b", i, serial_output, exp);
      end
      ntests++;
    end
    display_area = 1'b0;
    step();
  endtask

  task automatic test_display_drop();
    logic [7:0] a, b;
    logic [2:0] exp;
    a = 8'hA5; b = 8'h3C;
    msb_first = 1'b1;
    scale = 2'd0;
    load_word({3{a}});
    display_area = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      if (i == 1) ld.load_valid = 1'b0;
      exp = {3{a[7-i]}};
      if (serial_output !== exp) begin
        nfail++; $display("FAIL drop_pre[%0d]: got %b want %b", i, serial_output, exp);
      end
      ntests++;
      if (i == 0) begin
        ld.load_data  = {3{b}};
        ld.load_valid = 1'b1;
      end
    end
    display_area = 1'b0;
    step();
    if (serial_output !== 3'b000 || underrun !== 1'b0 || ld.load_ready !== 1'b0) begin
      nfail++; $display("FAIL drop_blank: got out=%b ur=%b rdy=%b want out=000 ur=0 rdy=0", serial_output, underrun, ld.load_ready);
    end
    ntests++;
    step();
    display_area = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      exp = {3{b[7-i]}};
      if (serial_output !== exp) begin
        nfail++; $display("FAIL drop_resume[%0d]: got %b want %b", i, serial_output, exp);
      end
      ntests++;
    end
    display_area = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_word();
    msb_first = 1'b1;
    scale = 2'd0;
    load_word({3{8'hA5}});
    display_area = 1'b1;
    step();
    ld.load_data  = {3{8'h3C}};
    ld.load_valid = 1'b1;
    step();
    ld.load_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    if (serial_output !== 3'b000 || underrun !== 1'b0 || ld.load_ready !== 1'b1) begin
      nfail++; $display("FAIL rst_mid: got out=%b ur=%b rdy=%b want out=000 ur=0 rdy=1", serial_output, underrun, ld.load_ready);
    end
    ntests++;
    reset = 1'b0;
    step();
    if (serial_output !== 3'b000 || underrun !== 1'b1) begin
      nfail++; $display("FAIL rst_dropped_hold: got out=%b ur=%b want out=000 ur=1", serial_output, underrun);
    end
    ntests++;
`ifdef VGA_PISO_UNDERRUN_CNT_EN
    if (underrun_count !== 16'd1) begin
      nfail++; $display("FAIL rst_count: got %0d want 1", underrun_count);
    end
    ntests++;
`endif
    display_area = 1'b0;
    step();
  endtask

  initial begin
    reset         = 1'b1;
    display_area  = 1'b0;
    msb_first     = 1'b1;
    scale         = '0;
    ld.load_data  = '0;
    ld.load_valid = 1'b0;
    test_reset();
    test_underrun();
    test_msb_first();
    test_lsb_scale();
    test_back_to_back();
    test_multi_lane();
    test_display_drop();
    test_reset_mid_word();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/vga_piso_shifter.md
Name: vga_piso_shifter

Overview:
- Parametrised, multi-channel parallel-in/serial-out pixel shifter for the VGA output path.
- Accepts packed glyph/bitmap words through a valid/ready handshake into a one-word holding buffer.
- Serialises each word onto NUM_CH colour lanes while display_area is high.
- Supports per-word bit order and horizontal pixel replication, and reports underruns when no word is available.

Parameters:
- DATA_W, 8: bits per word per channel; ≥2.
- NUM_CH, 1: number of parallel colour lanes, e.g. 3 for R/G/B.
- SCALE_W, 2: width of the scale input; each bit is held 1..2^SCALE_W cycles.

Ports:
- vga_clk  in  1  pixel clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- display_area  in  1  high during visible pixels.
- load_data  in  NUM_CH*DATA_W  word; channel c occupies bits [c*DATA_W +: DATA_W].
- load_valid  in  1  load_data is valid.
- load_ready  out  1  holding buffer can accept a word.
- msb_first  in  1  1 = bit DATA_W-1 first; 0 = bit 0 first.
- scale  in  SCALE_W  each bit is output for scale+1 cycles.
- serial_output  out  NUM_CH  current pixel bit per lane.
- underrun  out  1  one-cycle pulse per starved display cycle.

Behaviour:
- Reset: serial_output=0, underrun=0, holding buffer empty, shift register empty, bit_cnt=0, rep_cnt=0. load_ready is 1 on the first cycle after reset.
- load_ready = !hold_valid. This is a pure register decode with no combinational path from load_valid.
- Accept: load_valid && load_ready at an edge → hold_data<=load_data, hold_valid<=1. Accept is independent of display_area.
- Shifter states:
  - EMPTY: no word loaded.
  - SHIFT: word loaded; bit_cnt counts 0..DATA_W-1; rep_cnt counts 0..scale_q.
- Word-done: a SHIFT cycle with bit_cnt==DATA_W-1 and rep_cnt==scale_q.
- Transfer: occurs in a display_area=1 cycle when (state EMPTY or word-done) and hold_valid=1. Effects:
  - hold→shift register.
  - msb_first and scale are sampled into the word's own registers (msb_q, scale_q); changes mid-word have no effect.
  - bit_cnt=0, rep_cnt=0, state SHIFT, hold_valid<=0.
  - The same edge drives the word's first bit onto serial_output. Latency is 1 clock from transfer cycle to first visible bit.
- Word-done with no hold word: state→EMPTY. The next display cycle outputs 0 and pulses underrun.
- Back-to-back: a transfer on word-done gives gap-free output. load_ready rises the cycle after the transfer.
- Simultaneous accept and transfer in one cycle is impossible, because accept requires hold_valid=0 and transfer requires hold_valid=1.
- Per SHIFT cycle in display: serial_output[c] <= word[c][msb_q ? DATA_W-1-bit_cnt : bit_cnt].
  - rep_cnt increments; at scale_q it wraps to 0 and bit_cnt increments.
  - bit_cnt wraps only via word-done.
- display_area=0:
  - serial_output<=0, underrun<=0.
  - Shift register discarded, state→EMPTY, counters cleared.
  - Holding buffer retained.
  - Handshake continues.
- display_area=1 in EMPTY with hold_valid=0: serial_output<=0, underrun<=1 for that cycle.
- Reset mid-word: all state cleared as above, and any held word is dropped.
- All counters are $clog2-sized and never exceed their range.

Optional Feature:
- Macro VGA_PISO_UNDERRUN_CNT_EN.
- Defined: adds output port underrun_count [15:0], incremented on each underrun pulse, saturating at 16'hFFFF and cleared by reset.
- Undefined: the port and counter are absent; only the underrun pulse exists.

Decomposition:
- Package vga_piso_pkg holds:
  - BIT_CNT_W = $clog2(DATA_W) helper function
  - UNDERRUN_CNT_W = 16
  - state encoding localparams EMPTY=1'b0, SHIFT=1'b1
- Sub-module vga_piso_lane_mux: combinational bit select for one lane, given a DATA_W word, bit_cnt and msb_q. Instantiated NUM_CH times in a generate loop.
- Handshake and counters stay in the top module.

Test Plan:
- Reset, then display_area=1 with no load → serial_output=0 and underrun pulses every cycle; with the macro, underrun_count increments 1,2,3.
- DATA_W=8, NUM_CH=1, scale=0, msb_first=1: load 8'hA5 → serial_output 1,0,1,0,0,1,0,1 starting 1 clock after transfer; load_ready returns to 1 the cycle after transfer.
- Same word with msb_first=0, scale=1 → 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1. Toggling scale mid-word has no effect on that word.
- Back-to-back: load 8'hFF while the first 8'h00 is shifting → 8 zeros then 8 ones with no gap and no underrun.
- NUM_CH=3: load {8'hF0,8'h0F,8'hAA} → lane 2 outputs 11110000, lane 1 00001111, lane 0 10101010, all in parallel.
- display_area drops after 3 bits of 8'hA5 while 8'h3C is held → output 0, word discarded. On the next display_area=1, 8'h3C shifts from bit 0 of its sequence. Asserting reset mid-word → all outputs 0 and load_ready=1 on the next cycle.
